cmd_dispatcher: RTL and testbench

- Command front-end sitting directly upstream of the enclave controller.
- Accepts {opcode, op1/op2/out base address} commands from the host-side bus via a valid/ready handshake and buffers them in a small FIFO.
- Issues each command to the controller as a one-cycle config_en pulse, waits for the controller's done, then retires the command and launches the next.
- Serialises back-to-back ENCRYPT/DECRYPT/ADD/MULT jobs without host polling.

---
 rtl/cmd_dispatcher.sv | 149 ++++++++++++++
 tb/tb_cmd_dispatcher.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : cmd_dispatcher
// Purpose  : Buffers host commands in a small FIFO and issues them one at a
//            time to the enclave controller, retiring each on ctrl_done.
//            Optional macro DISPATCH_TIMEOUT_EN adds a BUSY-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_dispatcher #(
  parameter int ADDR_WIDTH     = 10,
  parameter int FIFO_DEPTH     = 4,
  parameter int PTR_WIDTH      = 2,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TIMEOUT_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_op1_base,
  input  logic [ADDR_WIDTH-1:0] cmd_op2_base,
  input  logic [ADDR_WIDTH-1:0] cmd_out_base,
  input  logic                  ctrl_done,
  output logic                  config_en,
  output logic [1:0]            opcode,
  output logic [ADDR_WIDTH-1:0] op1_base_addr,
  output logic [ADDR_WIDTH-1:0] op2_base_addr,
  output logic [ADDR_WIDTH-1:0] out_base_addr,
  output logic                  busy,
  output logic [PTR_WIDTH:0]    fifo_count,
  output logic                  irq_done,
  output logic [CNT_WIDTH-1:0]  completed_count,
  output logic                  timeout_err
);

  localparam int                c_ENTRY_W = 2 + 3 * ADDR_WIDTH;
  localparam logic [PTR_WIDTH:0] c_FULL   = (PTR_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    ARM  = 2'd2,
    BUSY = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   r_wr_ptr;
  logic [PTR_WIDTH-1:0]   r_rd_ptr;
  logic [PTR_WIDTH:0]     r_count;
  logic [c_ENTRY_W-1:0]   w_head;
  logic                   w_push;
  logic                   w_pop;

`ifdef DISPATCH_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] c_WDOG_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_WIDTH-1:0] r_wdog;
  logic                     r_timeout_err;
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  // Marker block elaborated only for an inconsistent parameter set.
  generate
    if ((1 << PTR_WIDTH) != FIFO_DEPTH || TIMEOUT_CYCLES < 1 ||
        TIMEOUT_CYCLES >= (1 << TIMEOUT_WIDTH)) begin : g_bad_params
    end
  endgenerate

  assign cmd_ready  = (r_count != c_FULL);
  assign fifo_count = r_count;
  assign busy       = (r_state != IDLE);
  assign w_push     = cmd_valid && cmd_ready;
  assign w_pop      = (r_state == IDLE) && (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_opcode, cmd_op1_base, cmd_op2_base, cmd_out_base};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      config_en       <= 1'b0;
      opcode          <= '0;
      op1_base_addr   <= '0;
      op2_base_addr   <= '0;
      out_base_addr   <= '0;
      irq_done        <= 1'b0;
      completed_count <= '0;
`ifdef DISPATCH_TIMEOUT_EN
      r_wdog          <= '0;
      r_timeout_err   <= 1'b0;
`endif
    end else begin
      config_en <= 1'b0;
      irq_done  <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;

      case (r_state)
        IDLE: begin
          if (w_pop) begin
            {opcode, op1_base_addr, op2_base_addr, out_base_addr} <= w_head;
            config_en <= 1'b1;
            r_state   <= CFG;
          end
        end
        CFG: r_state <= ARM;
        // Guard cycle: controller clears a stale done on the config edge.
        ARM: begin
`ifdef DISPATCH_TIMEOUT_EN
          r_wdog  <= '0;
`endif
          r_state <= BUSY;
        end
        BUSY: begin
          if (ctrl_done) begin
            irq_done        <= 1'b1;
            completed_count <= completed_count + 1'b1;
            r_state         <= IDLE;
          end
`ifdef DISPATCH_TIMEOUT_EN
          else if (r_wdog == c_WDOG_LAST) begin
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_dispatcher
// Purpose  : Directed scoreboard bench for cmd_dispatcher.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_dispatcher;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_opcode;
  logic [AW-1:0] cmd_op1_base, cmd_op2_base, cmd_out_base;
  logic          ctrl_done;
  logic          config_en;
  logic [1:0]    opcode;
  logic [AW-1:0] op1_base_addr, op2_base_addr, out_base_addr;
  logic          busy;
  logic [2:0]    fifo_count;
  logic          irq_done;
  logic [7:0]    completed_count;
  logic          timeout_err;

  int            n_total = 0;
  int            n_bad   = 0;
  int            n_irq   = 0;
  int            exp_irq = 0;
  int            exp_done = 0;
  logic          prev_cfg = 1'b0;
  logic [31:0]   m_exp;
  logic [31:0]   sb [$];

  always #5 clk = ~clk;

  cmd_dispatcher #(
    .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .PTR_WIDTH(2), .CNT_WIDTH(8),
    .TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_op1_base(cmd_op1_base), .cmd_op2_base(cmd_op2_base),
    .cmd_out_base(cmd_out_base), .ctrl_done(ctrl_done),
    .config_en(config_en), .opcode(opcode),
    .op1_base_addr(op1_base_addr), .op2_base_addr(op2_base_addr),
    .out_base_addr(out_base_addr), .busy(busy), .fifo_count(fifo_count),
    .irq_done(irq_done), .completed_count(completed_count),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each config pulse must carry the oldest accepted command, for one cycle.
  always @(negedge clk) begin
    if (rst_n && config_en) begin
      if (sb.size() == 0) begin
        chk("cfg_unexpected", sb.size(), 1);
      end else begin
        m_exp = sb.pop_front();
        chk("cfg_cmd", {opcode, op1_base_addr, op2_base_addr, out_base_addr}, m_exp);
      end
    end
    if (rst_n && prev_cfg) chk("cfg_one_cycle", config_en, 0);
    prev_cfg = rst_n && config_en;
    if (rst_n && irq_done) n_irq++;
  end

  task automatic drive(input logic [1:0] op, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [AW-1:0] c);
    cmd_valid    = 1'b1;
    cmd_opcode   = op;
    cmd_op1_base = a;
    cmd_op2_base = b;
    cmd_out_base = c;
  endtask

  task automatic push(input logic [1:0] op, input logic [AW-1:0] a,
                      input logic [AW-1:0] b, input logic [AW-1:0] c);
    logic acc;
    acc = 1'b0;
    drive(op, a, b, c);
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (acc) sb.push_back({op, a, b, c});
    else chk("push_timeout", acc, 1);
  endtask

  task automatic wait_cfg();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = config_en;
    end
    if (!seen) chk("wait_cfg_timeout", seen, 1);
  endtask

  task automatic done_pulse();
    ctrl_done = 1'b1;
    tick();
    ctrl_done = 1'b0;
    exp_done++;
    exp_irq++;
    chk("retire_irq", irq_done, 1);
    chk("retire_count", completed_count, exp_done);
  endtask

  task automatic retire_next();
    wait_cfg();
    tick();
    tick();
    done_pulse();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=stalled expected=finish");
    $fatal(1, "bench stalled");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; ctrl_done = 1'b0;
    cmd_opcode = '0; cmd_op1_base = '0; cmd_op2_base = '0; cmd_out_base = '0;
    tick(); tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_ctl", {config_en, busy, irq_done, timeout_err}, 0);
    chk("rst_count", {fifo_count, completed_count}, 0);
    chk("rst_data", {opcode, op1_base_addr, op2_base_addr, out_base_addr}, 0);
    rst_n = 1'b1;
    tick();

    // Single ADD command, latency and hold
    push(2'b10, 10'h010, 10'h020, 10'h030);
    chk("t1_count", fifo_count, 1);
    chk("t1_cfg_early", config_en, 0);
    tick();
    chk("t1_cfg", config_en, 1);
    chk("t1_pop", fifo_count, 0);
    tick();
    chk("t1_cfg_low", config_en, 0);
    tick();
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 9; i++) tick();
    chk("t1_hold", {opcode, op1_base_addr, op2_base_addr, out_base_addr},
        {2'b10, 10'h010, 10'h020, 10'h030});
    done_pulse();
    tick();
    chk("t1_irq_low", irq_done, 0);
    chk("t1_idle", busy, 0);

    // FIFO fill while a command is in flight
    push(2'b00, 10'h101, 10'h102, 10'h103);
    wait_cfg(); tick(); tick();
    push(2'b01, 10'h111, 10'h112, 10'h113);
    push(2'b10, 10'h121, 10'h122, 10'h123);
    push(2'b11, 10'h131, 10'h132, 10'h133);
    push(2'b00, 10'h141, 10'h142, 10'h143);
    chk("t2_full", fifo_count, 4);
    chk("t2_not_ready", cmd_ready, 0);
    drive(2'b01, 10'h151, 10'h152, 10'h153);
    tick(); tick(); tick();
    chk("t2_held", fifo_count, 4);
    done_pulse();
    push(2'b01, 10'h151, 10'h152, 10'h153);
    tick();
    done_pulse();
    for (int i = 0; i < 4; i++) retire_next();
    tick();
    chk("t2_drained", {busy, fifo_count}, 0);

    // Stale ctrl_done held high from IDLE
    ctrl_done = 1'b1;
    tick(); tick();
    chk("t3_idle_ignore", completed_count, exp_done);
    push(2'b11, 10'h201, 10'h202, 10'h203);
    tick(); tick(); tick();
    chk("t3_no_early", irq_done, 0);
    chk("t3_busy", busy, 1);
    tick();
    exp_done++; exp_irq++;
    chk("t3_retire", irq_done, 1);
    chk("t3_count", completed_count, exp_done);
    tick(); tick(); tick();
    chk("t3_no_double", completed_count, exp_done);
    ctrl_done = 1'b0;

    // Push coinciding with pop at occupancy 2
    push(2'b00, 10'h301, 10'h302, 10'h303);
    push(2'b01, 10'h311, 10'h312, 10'h313);
    push(2'b10, 10'h321, 10'h322, 10'h323);
    tick();
    chk("t4_two", fifo_count, 2);
    done_pulse();
    drive(2'b11, 10'h331, 10'h332, 10'h333);
    tick();
    cmd_valid = 1'b0;
    sb.push_back({2'b11, 10'h331, 10'h332, 10'h333});
    chk("t4_same", fifo_count, 2);
    chk("t4_cfg", config_en, 1);
    tick(); tick();
    done_pulse();
    retire_next();
    retire_next();

`ifndef DISPATCH_TIMEOUT_EN
    push(2'b11, 10'h351, 10'h352, 10'h353);
    for (int i = 0; i < 40; i++) tick();
    chk("t5_stall", {busy, timeout_err}, 2'b10);
    done_pulse();
`endif

    // Reset mid-BUSY with two queued
    push(2'b00, 10'h401, 10'h402, 10'h403);
    push(2'b01, 10'h411, 10'h412, 10'h413);
    push(2'b10, 10'h421, 10'h422, 10'h423);
    tick();
    chk("t6_pre", {busy, fifo_count}, {1'b1, 3'd2});
    rst_n = 1'b0;
    #1;
    chk("t6_ctl", {config_en, busy, irq_done, timeout_err, cmd_ready}, 5'b00001);
    chk("t6_count", {fifo_count, completed_count}, 0);
    chk("t6_data", {opcode, op1_base_addr, op2_base_addr, out_base_addr}, 0);
    sb.delete();
    exp_done = 0;
    tick(); tick();
    rst_n = 1'b1;
    ctrl_done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ctrl_done = 1'b0;
    chk("t6_after", {busy, fifo_count, completed_count}, 0);

`ifdef DISPATCH_TIMEOUT_EN
    push(2'b11, 10'h501, 10'h502, 10'h503);
    push(2'b00, 10'h511, 10'h512, 10'h513);
    tick(); tick();
    chk("t7_busy", busy, 1);
    for (int i = 0; i < 15; i++) tick();
    chk("t7_not_yet", timeout_err, 0);
    tick();
    chk("t7_err", timeout_err, 1);
    chk("t7_dropped", {irq_done, completed_count}, 0);
    retire_next();
    chk("t7_sticky", timeout_err, 1);
`endif

    tick(); tick();
    chk("irq_total", n_irq, exp_irq);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
